led_scan_ctrl: RTL



---
 rtl/led_pkg.sv | 20 ++
 rtl/led_slot_timer.sv | 53 +++++
 rtl/led_scan_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// A digit code carries the decimal point at DP_BIT and the hex value below it.
package led_pkg;

    localparam int DIG_CODE_W = 5;
    localparam int DP_BIT     = 4;

    typedef logic [DP_BIT:0] dig_code_t;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // Counter width that never collapses to zero bits for tiny parameters.
    function automatic int unsigned width_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/led_slot_timer.sv
// Slot and digit counters for the scan controller.
// Produces the slot-wrap and frame-wrap strobes used by the top level.
module led_slot_timer
    import led_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int CNT_W      = 16,
    parameter int IDX_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] idx,
    output logic             slot_wrap,
    output logic             frame_wrap
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic             slot_wrap_s;
    logic             frame_wrap_s;

    assign slot_wrap_s  = (cnt_r == CNT_LAST);
    // idx wraps explicitly at NUM_DIGITS-1 so non-power-of-2 banks stay in range.
    assign frame_wrap_s = slot_wrap_s && (idx_r == IDX_LAST);

    // Slot counter and digit index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (slot_wrap_s) begin
            cnt_r <= '0;
            if (frame_wrap_s) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign cnt        = cnt_r;
    assign idx        = idx_r;
    assign slot_wrap  = slot_wrap_s;
    assign frame_wrap = frame_wrap_s;

endmodule

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with a
// double-buffered frame interface; pins are registered one cycle after the counters.
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DIG_CODE_W*NUM_DIGITS-1:0] frame_data,
    input  logic                             frame_valid,
    output logic                             frame_ready,
    input  logic [NUM_DIGITS-1:0]            digit_en,
    output logic [DIG_CODE_W-1:0]            dig_ctrl,
    output logic                             dec_en,
    output logic [NUM_DIGITS-1:0]            dig_sel_n,
    output logic                             frame_done
);

    localparam int CNT_W = width_min1(SCAN_DIV);
    localparam int IDX_W = width_min1(NUM_DIGITS);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]      cnt_s;
    logic [IDX_W-1:0]      idx_s;
    logic                  slot_wrap_s;
    logic                  frame_wrap_s;
    scan_state_e           state_r;
    scan_state_e           state_nx_s;
    dig_code_t             frame_codes_s [NUM_DIGITS];
    dig_code_t             active_r      [NUM_DIGITS];
    dig_code_t             shadow_r      [NUM_DIGITS];
    logic                  pending_r;
    logic                  accept_s;
    logic [NUM_DIGITS-1:0] sel_nx_s;
    logic                  dec_en_nx_s;
    dig_code_t             ctrl_nx_s;
    logic [NUM_DIGITS-1:0] sel_r;
    logic                  dec_en_r;
    dig_code_t             ctrl_r;
    logic                  done_r;

    led_slot_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .CNT_W      (CNT_W),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .cnt        (cnt_s),
        .idx        (idx_s),
        .slot_wrap  (slot_wrap_s),
        .frame_wrap (frame_wrap_s)
    );

    // Split the flat frame bus into per-digit codes.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            frame_codes_s[i] = frame_data[i*DIG_CODE_W +: DIG_CODE_W];
        end
    end

    // Scan state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= BLANK;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; BLANK covers cnt < BLANK_CYC, so no blanking means SHOW only.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            BLANK: begin
                if ((BLANK_CYC == 0) || (cnt_s == BLANK_LAST)) begin
                    state_nx_s = SHOW;
                end else begin
                    state_nx_s = BLANK;
                end
            end
            SHOW: begin
                if (slot_wrap_s && (BLANK_CYC != 0)) begin
                    state_nx_s = BLANK;
                end else begin
                    state_nx_s = SHOW;
                end
            end
            default: state_nx_s = BLANK;
        endcase
    end

    assign accept_s    = frame_valid && !pending_r;
    assign frame_ready = ~pending_r;

    // Frame buffers: an accept landing on the boundary bypasses the shadow copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active_r[i] <= '0;
                shadow_r[i] <= '0;
            end
            pending_r <= 1'b0;
        end else if (frame_wrap_s && accept_s) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active_r[i] <= frame_codes_s[i];
            end
            pending_r <= 1'b0;
        end else if (frame_wrap_s && pending_r) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active_r[i] <= shadow_r[i];
            end
            pending_r <= 1'b0;
        end else if (accept_s) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_r[i] <= frame_codes_s[i];
            end
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Pin values for the next cycle; a masked digit looks exactly like blanking.
    always_comb begin
        sel_nx_s    = '1;
        dec_en_nx_s = 1'b0;
        ctrl_nx_s   = active_r[idx_s];
        if ((state_r == SHOW) && digit_en[idx_s]) begin
            sel_nx_s    = ~(SEL_ONE << idx_s);
            dec_en_nx_s = 1'b1;
        end else begin
            sel_nx_s    = '1;
            dec_en_nx_s = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r    <= '1;
            dec_en_r <= 1'b0;
            ctrl_r   <= '0;
            done_r   <= 1'b0;
        end else begin
            sel_r    <= sel_nx_s;
            dec_en_r <= dec_en_nx_s;
            ctrl_r   <= ctrl_nx_s;
            done_r   <= frame_wrap_s;
        end
    end

    assign dig_sel_n  = sel_r;
    assign dec_en     = dec_en_r;
    assign dig_ctrl   = ctrl_r;
    assign frame_done = done_r;

endmodule
